// File: rtl/gaussianblur_bus_arbiter.sv
// gaussianblur_bus_arbiter
//
// Shares one memory request/response port between the V1 and V2 bus masters of
// the Gaussianblur accelerator. The arbiter accepts one request in ARB, latches
// it, and presents it to memory in ISSUE until memory accepts it. Each read that
// is handed off pushes its owner into a tag FIFO. Read responses are routed
// combinationally, in order, to the owner at the head of that FIFO.
//
// Build option:
//   GBLUR_ARB_RR_EN  defined   : round-robin between the masters when both request
//                    undefined : V1 has fixed priority over V2
//
// Ports:
//   ap_clk, ap_rst_n          clock, synchronous active-low reset
//   vN_req_*, vN_address,
//   vN_size, vN_dataout       request side of master N (N = 1, 2)
//   vN_rsp_*, vN_datain       response side of master N
//   mem_req_*, mem_address,
//   mem_size, mem_dataout     request to memory (registered, held while stalled)
//   mem_rsp_*, mem_datain     response from memory
//   outstanding               reads handed off and not yet answered
//   rsp_orphan                sticky: a response arrived with no read outstanding
module gaussianblur_bus_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  // Master V1
  input  logic                         v1_req_write,
  input  logic                         v1_req_din,
  output logic                         v1_req_full_n,
  input  logic [ADDR_W-1:0]            v1_address,
  input  logic [ADDR_W-1:0]            v1_size,
  input  logic [DATA_W-1:0]            v1_dataout,
  output logic                         v1_rsp_empty_n,
  input  logic                         v1_rsp_read,
  output logic                         v1_rsp_dout,
  output logic [DATA_W-1:0]            v1_datain,
  // Master V2
  input  logic                         v2_req_write,
  input  logic                         v2_req_din,
  output logic                         v2_req_full_n,
  input  logic [ADDR_W-1:0]            v2_address,
  input  logic [ADDR_W-1:0]            v2_size,
  input  logic [DATA_W-1:0]            v2_dataout,
  output logic                         v2_rsp_empty_n,
  input  logic                         v2_rsp_read,
  output logic                         v2_rsp_dout,
  output logic [DATA_W-1:0]            v2_datain,
  // Memory side
  output logic                         mem_req_write,
  output logic                         mem_req_din,
  output logic [ADDR_W-1:0]            mem_address,
  output logic [ADDR_W-1:0]            mem_size,
  output logic [DATA_W-1:0]            mem_dataout,
  input  logic                         mem_req_full_n,
  input  logic                         mem_rsp_empty_n,
  output logic                         mem_rsp_read,
  input  logic                         mem_rsp_dout,
  input  logic [DATA_W-1:0]            mem_datain,
  // Status
  output logic [$clog2(TAG_DEPTH):0]   outstanding,
  output logic                         rsp_orphan
);

  localparam int unsigned PtrW = $clog2(TAG_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StArb, StIssue} state_e;

  state_e              state_q;
  logic                mem_req_write_q;
  logic                req_din_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   size_q;
  logic [DATA_W-1:0]   data_q;
  logic                owner_q;  // 0 = V1, 1 = V2

  // Tag FIFO: one owner bit per outstanding read
  logic                tag_mem_q [TAG_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q, count_d;
  logic                orphan_q;

  logic gnt_v1, gnt_v2;
  logic arb_ok, accept_v1, accept_v2, accept;
  logic push, pop, tag_full, tag_empty, head;

  // ---------------------------------------------------------------------------
  // Grant
  // ---------------------------------------------------------------------------
`ifdef GBLUR_ARB_RR_EN
  logic last_v2_q;  // 1 = V2 was granted last; reset value lets V1 win the first tie

  assign gnt_v1 = v1_req_write & (~v2_req_write | last_v2_q);

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      last_v2_q <= 1'b1;
    end else if (accept) begin
      last_v2_q <= accept_v2;
    end
  end
`else
  assign gnt_v1 = v1_req_write;
`endif
  assign gnt_v2 = v2_req_write & ~gnt_v1;

  assign tag_empty = (count_q == '0);
  assign tag_full  = (count_q == CntW'(TAG_DEPTH));
  assign arb_ok    = (state_q == StArb) & ~tag_full;

  // Ready is forced low while reset is held, whatever the state register holds
  assign v1_req_full_n = ap_rst_n & arb_ok & gnt_v1;
  assign v2_req_full_n = ap_rst_n & arb_ok & gnt_v2;

  assign accept_v1 = v1_req_write & v1_req_full_n;
  assign accept_v2 = v2_req_write & v2_req_full_n;
  assign accept    = accept_v1 | accept_v2;

  // ---------------------------------------------------------------------------
  // Request FSM with registered memory-side outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q         <= StArb;
      mem_req_write_q <= 1'b0;
      req_din_q       <= 1'b0;
      addr_q          <= '0;
      size_q          <= '0;
      data_q          <= '0;
      owner_q         <= 1'b0;
    end else begin
      unique case (state_q)
        StArb: begin
          if (accept) begin
            state_q         <= StIssue;
            mem_req_write_q <= 1'b1;
            owner_q         <= accept_v2;
            req_din_q       <= accept_v2 ? v2_req_din : v1_req_din;
            addr_q          <= accept_v2 ? v2_address : v1_address;
            size_q          <= accept_v2 ? v2_size    : v1_size;
            data_q          <= accept_v2 ? v2_dataout : v1_dataout;
          end
        end
        StIssue: begin
          if (mem_req_full_n) begin
            state_q         <= StArb;
            mem_req_write_q <= 1'b0;
          end
        end
        default: begin
          state_q         <= StArb;
          mem_req_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_write = mem_req_write_q;
  assign mem_req_din   = req_din_q;
  assign mem_address   = addr_q;
  assign mem_size      = size_q;
  assign mem_dataout   = data_q;

  // ---------------------------------------------------------------------------
  // Tag FIFO
  // ---------------------------------------------------------------------------
  // A read's tag enters the FIFO on the same edge the request is handed off
  assign push = (state_q == StIssue) & mem_req_full_n & ~req_din_q;
  assign pop  = mem_rsp_read;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (push) begin
      tag_mem_q[wr_ptr_q] <= owner_q;
    end
  end

  // Pointers wrap naturally because TAG_DEPTH is a power of two
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      orphan_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q  <= count_d;
      orphan_q <= orphan_q | (mem_rsp_empty_n & tag_empty);
    end
  end

  assign outstanding = count_q;
  assign rsp_orphan  = orphan_q;

  // ---------------------------------------------------------------------------
  // Response routing (zero-cycle)
  // ---------------------------------------------------------------------------
  assign head = tag_mem_q[rd_ptr_q];

  assign v1_rsp_empty_n = mem_rsp_empty_n & ~tag_empty & ~head;
  assign v2_rsp_empty_n = mem_rsp_empty_n & ~tag_empty &  head;

  assign v1_datain   = mem_datain;
  assign v2_datain   = mem_datain;
  assign v1_rsp_dout = mem_rsp_dout;
  assign v2_rsp_dout = mem_rsp_dout;

  assign mem_rsp_read = (v1_rsp_read & v1_rsp_empty_n) | (v2_rsp_read & v2_rsp_empty_n);

endmodule

// File: tb/tb_gaussianblur_bus_arbiter.sv
// Directed bench for gaussianblur_bus_arbiter. Handed-off requests and routed
// read responses are checked against scoreboard queues filled when stimulus is
// accepted; cycle-level behaviour is checked inline.
module tb_gaussianblur_bus_arbiter;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          v1_req_write = 0, v1_req_din = 0, v1_rsp_read = 0;
  logic          v2_req_write = 0, v2_req_din = 0, v2_rsp_read = 0;
  logic [31:0]   v1_address = 0, v1_size = 0, v2_address = 0, v2_size = 0;
  logic [127:0]  v1_dataout = 0, v2_dataout = 0;
  logic          v1_req_full_n, v1_rsp_empty_n, v1_rsp_dout;
  logic          v2_req_full_n, v2_rsp_empty_n, v2_rsp_dout;
  logic [127:0]  v1_datain, v2_datain;
  logic          mem_req_write, mem_req_din, mem_rsp_read;
  logic [31:0]   mem_address, mem_size;
  logic [127:0]  mem_dataout;
  logic          mem_req_full_n = 1'b1, mem_rsp_empty_n = 1'b0, mem_rsp_dout = 1'b0;
  logic [127:0]  mem_datain = '0;
  logic [2:0]    outstanding;
  logic          rsp_orphan;

  int total = 0;
  int bad   = 0;

  logic [32:0] exp_req_q [$];  // {din, address} in acceptance order
  int          exp_own_q [$];  // owner (1/2) of each accepted read
  logic        last_v2 = 1'b1;

  gaussianblur_bus_arbiter dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .v1_req_write    (v1_req_write),
    .v1_req_din      (v1_req_din),
    .v1_req_full_n   (v1_req_full_n),
    .v1_address      (v1_address),
    .v1_size         (v1_size),
    .v1_dataout      (v1_dataout),
    .v1_rsp_empty_n  (v1_rsp_empty_n),
    .v1_rsp_read     (v1_rsp_read),
    .v1_rsp_dout     (v1_rsp_dout),
    .v1_datain       (v1_datain),
    .v2_req_write    (v2_req_write),
    .v2_req_din      (v2_req_din),
    .v2_req_full_n   (v2_req_full_n),
    .v2_address      (v2_address),
    .v2_size         (v2_size),
    .v2_dataout      (v2_dataout),
    .v2_rsp_empty_n  (v2_rsp_empty_n),
    .v2_rsp_read     (v2_rsp_read),
    .v2_rsp_dout     (v2_rsp_dout),
    .v2_datain       (v2_datain),
    .mem_req_write   (mem_req_write),
    .mem_req_din     (mem_req_din),
    .mem_address     (mem_address),
    .mem_size        (mem_size),
    .mem_dataout     (mem_dataout),
    .mem_req_full_n  (mem_req_full_n),
    .mem_rsp_empty_n (mem_rsp_empty_n),
    .mem_rsp_read    (mem_rsp_read),
    .mem_rsp_dout    (mem_rsp_dout),
    .mem_datain      (mem_datain),
    .outstanding     (outstanding),
    .rsp_orphan      (rsp_orphan)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ap_clk);
    #2;
  endtask

  // Scoreboard monitor, sampled mid-cycle on the falling edge
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (mem_req_write && mem_req_full_n) begin
        if (exp_req_q.size() == 0) chk("handoff_unexpected", 128'(mem_address), 128'hdead);
        else chk("handoff_req", 128'({mem_req_din, mem_address}), 128'(exp_req_q.pop_front()));
      end
      if (mem_rsp_read) begin
        if (exp_own_q.size() == 0) begin
          chk("rsp_unexpected", 128'(mem_rsp_read), 128'(0));
        end else begin
          int o;
          o = exp_own_q.pop_front();
          chk("rsp_owner", 128'({v2_rsp_read & v2_rsp_empty_n, v1_rsp_read & v1_rsp_empty_n}),
              (o == 2) ? 128'(2'b10) : 128'(2'b01));
          chk("rsp_data", (o == 2) ? v2_datain : v1_datain, mem_datain);
        end
      end
    end
  end

  // Present a request from master m and hold it until accepted (bounded)
  task automatic do_req(input int m, input logic din, input logic [31:0] addr);
    int n;
    n = 0;
    if (m == 1) begin
      v1_req_write = 1'b1; v1_req_din = din; v1_address = addr; v1_size = 32'd16;
      v1_dataout = {4{addr}};
    end else begin
      v2_req_write = 1'b1; v2_req_din = din; v2_address = addr; v2_size = 32'd16;
      v2_dataout = {4{addr}};
    end
    #1;
    while (!((m == 1) ? v1_req_full_n : v2_req_full_n) && n < 50) begin
      cyc();
      n++;
    end
    chk("req_accept", 128'((m == 1) ? v1_req_full_n : v2_req_full_n), 128'(1));
    exp_req_q.push_back({din, addr});
    if (!din) exp_own_q.push_back(m);
    last_v2 = (m == 2);
    cyc();
    if (m == 1) v1_req_write = 1'b0;
    else        v2_req_write = 1'b0;
  endtask

  // Memory returns n responses, both masters ready to consume
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      mem_rsp_empty_n = 1'b1;
      mem_datain = {4{32'hC0DE0000 + 32'(i)}};
      mem_rsp_dout = i[0];
      v1_rsp_read = 1'b1;
      v2_rsp_read = 1'b1;
      #1;
      chk("drain_read", 128'(mem_rsp_read), 128'(1));
      chk("drain_dout", 128'(v1_rsp_dout), 128'(i[0]));
      cyc();
    end
    mem_rsp_empty_n = 1'b0;
    v1_rsp_read = 1'b0;
    v2_rsp_read = 1'b0;
  endtask

  initial begin
    int g, eg, n;

    // ---- reset ----
    v1_req_write = 1'b1;
    #1;
    chk("rst_full_n_forced", 128'(v1_req_full_n), 128'(0));
    cyc(); cyc();
    chk("rst_full_n_held", 128'(v1_req_full_n), 128'(0));
    v1_req_write = 1'b0;
    ap_rst_n = 1'b1;
    #1;
    chk("rst_mem_req_write", 128'(mem_req_write), 128'(0));
    chk("rst_outstanding", 128'(outstanding), 128'(0));
    chk("rst_orphan", 128'(rsp_orphan), 128'(0));
    chk("rst_mem_rsp_read", 128'(mem_rsp_read), 128'(0));
    chk("rst_mem_address", 128'(mem_address), 128'(0));
    chk("rst_rsp_empty_n", 128'({v2_rsp_empty_n, v1_rsp_empty_n}), 128'(0));

    // ---- single read ----
    cyc();
    v1_req_write = 1'b1; v1_req_din = 1'b0; v1_address = 32'h100; v1_size = 32'd16;
    #1;
    chk("single_v1_ready", 128'(v1_req_full_n), 128'(1));
    chk("single_v2_ready", 128'(v2_req_full_n), 128'(0));
    exp_req_q.push_back({1'b0, 32'h100});
    exp_own_q.push_back(1);
    last_v2 = 1'b0;
    cyc();
    v1_req_write = 1'b0;
    #1;
    chk("single_mem_write_t1", 128'(mem_req_write), 128'(1));
    chk("single_mem_addr_t1", 128'(mem_address), 128'(32'h100));
    chk("single_mem_size_t1", 128'(mem_size), 128'(16));
    chk("single_outst_t1", 128'(outstanding), 128'(0));
    chk("single_busy_ready", 128'(v1_req_full_n), 128'(0));
    cyc();
    chk("single_outst_t2", 128'(outstanding), 128'(1));
    chk("single_mem_write_t2", 128'(mem_req_write), 128'(0));
    mem_rsp_empty_n = 1'b1; mem_datain = {4{32'hA5A5A5A5}}; v1_rsp_read = 1'b1;
    #1;
    chk("single_v1_rsp", 128'(v1_rsp_empty_n), 128'(1));
    chk("single_v2_rsp", 128'(v2_rsp_empty_n), 128'(0));
    chk("single_v1_data", v1_datain, {4{32'hA5A5A5A5}});
    cyc();
    mem_rsp_empty_n = 1'b0; v1_rsp_read = 1'b0;
    #1;
    chk("single_outst_t3", 128'(outstanding), 128'(0));

    // ---- contention: 8 acceptances in two rounds of 4 ----
    for (int r = 0; r < 2; r++) begin
      v1_req_write = 1'b1; v1_req_din = 1'b0; v1_address = 32'h1000;
      v2_req_write = 1'b1; v2_req_din = 1'b0; v2_address = 32'h2000;
      for (int k = 0; k < 4; k++) begin
        n = 0;
        #1;
        while (!(v1_req_full_n | v2_req_full_n) && n < 50) begin
          cyc();
          n++;
        end
        g = v2_req_full_n ? 2 : (v1_req_full_n ? 1 : 0);
`ifdef GBLUR_ARB_RR_EN
        eg = last_v2 ? 1 : 2;
`else
        eg = 1;
`endif
        chk("contention_grant", 128'(g), 128'(eg));
        exp_req_q.push_back({1'b0, (eg == 2) ? 32'h2000 : 32'h1000});
        exp_own_q.push_back(eg);
        last_v2 = (eg == 2);
        cyc();
      end
      v1_req_write = 1'b0;
      v2_req_write = 1'b0;
      cyc();
      chk("contention_outst", 128'(outstanding), 128'(4));
      drain(4);
    end

    // ---- backpressure ----
    mem_req_full_n = 1'b0;
    do_req(1, 1'b0, 32'h300);
    v2_req_write = 1'b1; v2_req_din = 1'b1; v2_address = 32'h400;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_mem_write", 128'(mem_req_write), 128'(1));
      chk("bp_mem_addr", 128'(mem_address), 128'(32'h300));
      chk("bp_ready", 128'({v2_req_full_n, v1_req_full_n}), 128'(0));
      cyc();
    end
    mem_req_full_n = 1'b1;
    do_req(2, 1'b1, 32'h400);
    cyc();
    chk("bp_outst", 128'(outstanding), 128'(1));
    drain(1);

    // ---- tag full ----
    do_req(1, 1'b0, 32'h600);
    do_req(2, 1'b0, 32'h610);
    do_req(1, 1'b0, 32'h620);
    do_req(2, 1'b0, 32'h630);
    cyc();
    chk("full_outst", 128'(outstanding), 128'(4));
    v1_req_write = 1'b1; v1_req_din = 1'b1; v1_address = 32'h640;
    v2_req_write = 1'b1; v2_req_din = 1'b0; v2_address = 32'h650;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_refused", 128'({v2_req_full_n, v1_req_full_n}), 128'(0));
      cyc();
    end
    v1_req_write = 1'b0;
    v2_req_write = 1'b0;
    drain(1);
    do_req(1, 1'b0, 32'h660);
    cyc();
    chk("full_outst_again", 128'(outstanding), 128'(4));
    drain(4);

    // ---- ordering with a stalled consumer ----
    do_req(1, 1'b0, 32'h700);
    do_req(2, 1'b0, 32'h710);
    do_req(1, 1'b0, 32'h720);
    cyc();
    mem_rsp_empty_n = 1'b1; mem_datain = {4{32'h5A5A5A5A}};
    v1_rsp_read = 1'b0; v2_rsp_read = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("order_head_v1", 128'({v2_rsp_empty_n, v1_rsp_empty_n}), 128'(2'b01));
      chk("order_blocked", 128'(mem_rsp_read), 128'(0));
      cyc();
    end
    drain(3);
    chk("sb_req_empty", 128'(exp_req_q.size()), 128'(0));
    chk("sb_own_empty", 128'(exp_own_q.size()), 128'(0));
    chk("no_orphan_yet", 128'(rsp_orphan), 128'(0));

    // ---- reset while active, then orphan ----
    do_req(1, 1'b0, 32'h800);
    do_req(2, 1'b0, 32'h810);
    cyc();
    chk("pre_rst_outst", 128'(outstanding), 128'(2));
    ap_rst_n = 1'b0;
    v1_req_write = 1'b1; v1_req_din = 1'b0;
    exp_req_q.delete();
    exp_own_q.delete();
    #1;
    chk("rst_active_ready", 128'(v1_req_full_n), 128'(0));
    cyc();
    ap_rst_n = 1'b1;
    v1_req_write = 1'b0;
    last_v2 = 1'b1;
    #1;
    chk("rst2_outst", 128'(outstanding), 128'(0));
    chk("rst2_mem_write", 128'(mem_req_write), 128'(0));
    chk("rst2_mem_addr", 128'(mem_address), 128'(0));
    chk("rst2_rsp_empty_n", 128'({v2_rsp_empty_n, v1_rsp_empty_n}), 128'(0));
    chk("rst2_orphan", 128'(rsp_orphan), 128'(0));
    v1_req_write = 1'b1; v2_req_write = 1'b1;
    #1;
    chk("rst2_first_tie", 128'({v2_req_full_n, v1_req_full_n}), 128'(2'b01));
    v1_req_write = 1'b0; v2_req_write = 1'b0;
    mem_rsp_empty_n = 1'b1; v1_rsp_read = 1'b1; v2_rsp_read = 1'b1;
    #1;
    chk("orphan_no_read", 128'(mem_rsp_read), 128'(0));
    cyc();
    chk("orphan_set", 128'(rsp_orphan), 128'(1));
    mem_rsp_empty_n = 1'b0; v1_rsp_read = 1'b0; v2_rsp_read = 1'b0;
    cyc();
    chk("orphan_sticky", 128'(rsp_orphan), 128'(1));
    ap_rst_n = 1'b0;
    cyc();
    ap_rst_n = 1'b1;
    #1;
    chk("orphan_cleared", 128'(rsp_orphan), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
